// File: rtl/ror_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ror_pkg
//  Brief    : Shared definitions for the radius-outlier-removal output stage:
//             default data width and the writer's state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package ror_pkg;

  // Coordinate and index width used unless a block overrides it.
  localparam int N_DEFAULT = 16;

  // Point memory read latency supported by this revision.
  localparam int MEM_LATENCY_DEFAULT = 1;

  // Writer sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/outlier_point_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : outlier_point_writer_if
//  Brief    : Valid/ready stream carrying one kept point (x, y, z and its
//             original index) from the writer to the result sink.
//  Revision : 1.0 - initial release
// ============================================================================
interface outlier_point_writer_if
  import ror_pkg::*;
#(
  parameter int N = N_DEFAULT
);

  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_x;
  logic [N-1:0] out_y;
  logic [N-1:0] out_z;
  logic [N-1:0] out_index;

  // Point source (the writer).
  modport master (
    output out_valid, out_x, out_y, out_z, out_index,
    input  out_ready
  );

  // Point sink.
  modport slave (
    input  out_valid, out_x, out_y, out_z, out_index,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/point_out_reg.sv
`default_nettype none
// ============================================================================
//  Module   : point_out_reg
//  Brief    : One-entry output register for kept points. A load marks the
//             entry valid; the memory data arrives during the following
//             cycle and is passed straight through, then held locally so
//             the coordinates stay stable while the sink stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module point_out_reg
  import ror_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [N-1:0] load_index_i,
  input  logic [N-1:0] mem_x_i,
  input  logic [N-1:0] mem_y_i,
  input  logic [N-1:0] mem_z_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [N-1:0] x_o,
  output logic [N-1:0] y_o,
  output logic [N-1:0] z_o,
  output logic [N-1:0] index_o,
  output logic         slot_free_o
);

  logic         valid_q;
  logic         fresh_q;   // memory data for the entry is on mem_*_i this cycle
  logic [N-1:0] index_q;
  logic [N-1:0] x_q;
  logic [N-1:0] y_q;
  logic [N-1:0] z_q;

  // Entry occupancy: a load fills it, an accepted transfer empties it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      fresh_q <= 1'b0;
      index_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      fresh_q <= 1'b1;
      index_q <= load_index_i;
    end else begin
      fresh_q <= 1'b0;
      if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Capture the returning read data so a stalled entry keeps its coordinates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else if (fresh_q) begin
      x_q <= mem_x_i;
      y_q <= mem_y_i;
      z_q <= mem_z_i;
    end
  end

  assign valid_o     = valid_q;
  assign index_o     = index_q;
  assign x_o         = fresh_q ? mem_x_i : x_q;
  assign y_o         = fresh_q ? mem_y_i : y_q;
  assign z_o         = fresh_q ? mem_z_i : z_q;
  // A new read may issue when the entry is empty or leaving this cycle.
  assign slot_free_o = !valid_q || ready_i;

endmodule
`default_nettype wire

// File: rtl/outlier_point_writer.sv
`default_nettype none
// ============================================================================
//  Module   : outlier_point_writer
//  Brief    : Walks point indices 0..size-1, drops every index named by the
//             ascending outlier FIFO, reads the remaining points from point
//             memory and streams them to the sink. Out-of-order, duplicate
//             or out-of-range FIFO entries are popped and flagged.
//  Revision : 1.0 - initial release
// ============================================================================
module outlier_point_writer
  import ror_pkg::*;
#(
  parameter int N           = N_DEFAULT,
  parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [N-1:0]             point_cloud_size_i,
  input  logic [N-1:0]             outlier_pos_i,
  input  logic                     empty_i,
  output logic                     read_fifo_o,
  output logic                     mem_rd_o,
  output logic [N-1:0]             mem_addr_o,
  input  logic [N-1:0]             mem_x_i,
  input  logic [N-1:0]             mem_y_i,
  input  logic [N-1:0]             mem_z_i,
  outlier_point_writer_if.master   out_if,
  output logic [N-1:0]             kept_count_o,
  output logic [N-1:0]             removed_count_o,
  output logic                     order_error_o,
  output logic                     done_o
);

  // The output register assumes read data returns exactly one cycle later.
  generate
    if (MEM_LATENCY != 1) begin : g_latency_check
      $error("outlier_point_writer supports MEM_LATENCY = 1 only");
    end
  endgenerate

  state_e       state_q, state_d;
  logic [N-1:0] idx_q, idx_d;         // next index to evaluate
  logic [N-1:0] size_q, size_d;       // point count latched at run start
  logic [N-1:0] kept_q, kept_d;
  logic [N-1:0] removed_q, removed_d;
  logic         err_q, err_d;
  logic         slot_free;
  logic         accept;

  point_out_reg #(
    .N (N)
  ) u_out_reg (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_i       (mem_rd_o),
    .load_index_i (idx_q),
    .mem_x_i      (mem_x_i),
    .mem_y_i      (mem_y_i),
    .mem_z_i      (mem_z_i),
    .ready_i      (out_if.out_ready),
    .valid_o      (out_if.out_valid),
    .x_o          (out_if.out_x),
    .y_o          (out_if.out_y),
    .z_o          (out_if.out_z),
    .index_o      (out_if.out_index),
    .slot_free_o  (slot_free)
  );

  assign accept = out_if.out_valid && out_if.out_ready;

  // State, index and run statistics registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      size_q    <= '0;
      kept_q    <= '0;
      removed_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      size_q    <= size_d;
      kept_q    <= kept_d;
      removed_q <= removed_d;
      err_q     <= err_d;
    end
  end

  // Sequencing and per-cycle issue decision: drop, flag or read index i.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    size_d      = size_q;
    kept_d      = accept ? kept_q + 1'b1 : kept_q;
    removed_d   = removed_q;
    err_d       = err_q;
    read_fifo_o = 1'b0;
    mem_rd_o    = 1'b0;
    mem_addr_o  = '0;
    done_o      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          idx_d     = '0;
          size_d    = point_cloud_size_i;
          kept_d    = '0;
          removed_d = '0;
          err_d     = 1'b0;
          state_d   = (point_cloud_size_i == '0) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        if (idx_q < size_q) begin
          if (slot_free) begin
            if (!empty_i && (outlier_pos_i == idx_q)) begin
              read_fifo_o = 1'b1;
              removed_d   = removed_q + 1'b1;
              idx_d       = idx_q + 1'b1;
            end else if (!empty_i && (outlier_pos_i < idx_q)) begin
              // Stale or repeated entry: discard it and look again at i.
              read_fifo_o = 1'b1;
              err_d       = 1'b1;
            end else begin
              mem_rd_o    = 1'b1;
              mem_addr_o  = idx_q;
              idx_d       = idx_q + 1'b1;
            end
          end
        end else if (!out_if.out_valid) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Anything still queued names an index beyond the cloud.
        if (!empty_i) begin
          read_fifo_o = 1'b1;
          err_d       = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done_o = 1'b1;
        if (!start_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign kept_count_o    = kept_q;
  assign removed_count_o = removed_q;
  assign order_error_o   = err_q;

endmodule
`default_nettype wire
